// File: rtl/param_menu_ctrl.sv
// Menu controller for a bank of parameter cells: one-hot selection, restore routing,
// inactivity timeout, and preset recall from an external store into the cells' load ports.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | menu closed, no cell selected, last sel_idx remembered
// ACTIVE  | menu open, cell sel_idx selected, timeout running
// LD_RD   | issue one preset store read for entry ld_idx
// LD_WAIT | wait for the store's read data
// LD_WR   | strobe load_valid for entry ld_idx, then advance or return
module param_menu_ctrl #(
    parameter int NUM_PARAMS   = 8,
    parameter int IDX_WIDTH    = 3,
    parameter int PARAM_WIDTH  = 8,
    parameter int PRESET_WIDTH = 2,
    parameter int TIMEOUT_MS   = 5000
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              pulse_ms,
    input  logic                              key_next,
    input  logic                              key_prev,
    input  logic                              key_restore,
    input  logic                              preset_req,
    input  logic [PRESET_WIDTH-1:0]           preset_id,
    output logic                              mem_rd_en,
    output logic [PRESET_WIDTH+IDX_WIDTH-1:0] mem_rd_addr,
    input  logic                              mem_rd_valid,
    input  logic [PARAM_WIDTH-1:0]            mem_rd_data,
    output logic [NUM_PARAMS-1:0]             sel_onehot,
    output logic [IDX_WIDTH-1:0]              sel_idx,
    output logic                              restore,
    output logic [NUM_PARAMS-1:0]             load_valid,
    output logic [PARAM_WIDTH-1:0]            load_data,
    output logic                              menu_active,
    output logic                              busy
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_MS + 1);
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_PARAMS - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(TIMEOUT_MS - 1);
    localparam logic [NUM_PARAMS-1:0] ONE_HOT0 = NUM_PARAMS'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACTIVE  = 3'd1,
        LD_RD   = 3'd2,
        LD_WAIT = 3'd3,
        LD_WR   = 3'd4
    } state_t;

    state_t                            state, state_nxt;
    state_t                            ret_state, ret_state_nxt;
    logic [CNT_WIDTH-1:0]              cnt, cnt_nxt;
    logic [IDX_WIDTH-1:0]              ld_idx, ld_idx_nxt;
    logic [PRESET_WIDTH-1:0]           preset, preset_nxt;
    logic [IDX_WIDTH-1:0]              sel_idx_nxt;
    logic [PARAM_WIDTH-1:0]            load_data_nxt;
    logic [NUM_PARAMS-1:0]             load_valid_nxt;
    logic [NUM_PARAMS-1:0]             sel_onehot_nxt;
    logic [PRESET_WIDTH+IDX_WIDTH-1:0] mem_rd_addr_nxt;
    logic                              mem_rd_en_nxt;
    logic                              restore_nxt;
    logic                              menu_active_nxt;
    logic                              busy_nxt;
    logic                              any_key;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            ret_state   <= IDLE;
            cnt         <= '0;
            ld_idx      <= '0;
            preset      <= '0;
            sel_idx     <= '0;
            sel_onehot  <= '0;
            restore     <= 1'b0;
            load_valid  <= '0;
            load_data   <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            menu_active <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            ret_state   <= ret_state_nxt;
            cnt         <= cnt_nxt;
            ld_idx      <= ld_idx_nxt;
            preset      <= preset_nxt;
            sel_idx     <= sel_idx_nxt;
            sel_onehot  <= sel_onehot_nxt;
            restore     <= restore_nxt;
            load_valid  <= load_valid_nxt;
            load_data   <= load_data_nxt;
            mem_rd_en   <= mem_rd_en_nxt;
            mem_rd_addr <= mem_rd_addr_nxt;
            menu_active <= menu_active_nxt;
            busy        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        ret_state_nxt   = ret_state;
        cnt_nxt         = cnt;
        ld_idx_nxt      = ld_idx;
        preset_nxt      = preset;
        sel_idx_nxt     = sel_idx;
        load_data_nxt   = load_data;
        load_valid_nxt  = '0;
        restore_nxt     = 1'b0;
        mem_rd_en_nxt   = 1'b0;
        mem_rd_addr_nxt = mem_rd_addr;
        any_key         = key_next | key_prev | key_restore;

        case (state)
            IDLE, ACTIVE: begin
                if (preset_req) begin
                    // Recall wins over any same-cycle key press.
                    preset_nxt      = preset_id;
                    ret_state_nxt   = state;
                    ld_idx_nxt      = '0;
                    state_nxt       = LD_RD;
                    mem_rd_en_nxt   = 1'b1;
                    mem_rd_addr_nxt = {preset_id, IDX_WIDTH'(0)};
                end else if (state == IDLE) begin
                    if (key_next || key_prev) begin
                        state_nxt = ACTIVE;
                        cnt_nxt   = '0;
                    end
                end else if (any_key) begin
                    cnt_nxt = '0;
                    if (key_restore) begin
                        restore_nxt = 1'b1;
                    end else if (key_next && !key_prev) begin
                        sel_idx_nxt = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
                    end else if (key_prev && !key_next) begin
                        sel_idx_nxt = (sel_idx == '0) ? LAST_IDX : sel_idx - 1'b1;
                    end
                end else if (pulse_ms) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            LD_RD: begin
                state_nxt = LD_WAIT;
            end
            LD_WAIT: begin
                if (mem_rd_valid) begin
                    load_data_nxt  = mem_rd_data;
                    load_valid_nxt = ONE_HOT0 << ld_idx;
                    state_nxt      = LD_WR;
                end
            end
            LD_WR: begin
                if (ld_idx == LAST_IDX) begin
                    state_nxt = ret_state;
                    if (ret_state == ACTIVE) begin
                        cnt_nxt = '0;
                    end
                end else begin
                    ld_idx_nxt      = ld_idx + 1'b1;
                    state_nxt       = LD_RD;
                    mem_rd_en_nxt   = 1'b1;
                    mem_rd_addr_nxt = {preset, ld_idx + 1'b1};
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        menu_active_nxt = (state_nxt == ACTIVE);
        busy_nxt        = (state_nxt == LD_RD) || (state_nxt == LD_WAIT) || (state_nxt == LD_WR);
        sel_onehot_nxt  = (state_nxt == ACTIVE) ? (ONE_HOT0 << sel_idx_nxt) : '0;
    end

endmodule

// File: tb/tb_param_menu_ctrl.sv
// Directed bench for param_menu_ctrl: navigation, restore, preset recall, timeout, reset abort.
module tb_param_menu_ctrl;
    localparam int NP  = 8;
    localparam int IW  = 3;
    localparam int PW  = 8;
    localparam int PRW = 2;
    localparam int TMO = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic pulse_ms = 1'b0;
    logic key_next = 1'b0;
    logic key_prev = 1'b0;
    logic key_restore = 1'b0;
    logic preset_req = 1'b0;
    logic [PRW-1:0] preset_id = '0;
    logic mem_rd_en;
    logic [PRW+IW-1:0] mem_rd_addr;
    logic mem_rd_valid = 1'b0;
    logic [PW-1:0] mem_rd_data = '0;
    logic [NP-1:0] sel_onehot;
    logic [IW-1:0] sel_idx;
    logic restore;
    logic [NP-1:0] load_valid;
    logic [PW-1:0] load_data;
    logic menu_active;
    logic busy;

    int passed = 0;
    int total = 0;
    int fix_lat = 1;
    bit rand_lat = 1'b0;
    bit stray_en = 1'b0;

    logic [PRW+IW-1:0] addr_log[8];
    logic [NP-1:0] lv_log[8];
    logic [PW-1:0] ld_log[8];
    int n_rd, n_lv, busy_cyc, first_lv, first_rd, bad_sel;

    param_menu_ctrl #(
        .NUM_PARAMS(NP), .IDX_WIDTH(IW), .PARAM_WIDTH(PW),
        .PRESET_WIDTH(PRW), .TIMEOUT_MS(TMO)
    ) dut (
        .clk(clk), .resetn(resetn), .pulse_ms(pulse_ms),
        .key_next(key_next), .key_prev(key_prev), .key_restore(key_restore),
        .preset_req(preset_req), .preset_id(preset_id),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .sel_onehot(sel_onehot), .sel_idx(sel_idx), .restore(restore),
        .load_valid(load_valid), .load_data(load_data),
        .menu_active(menu_active), .busy(busy)
    );

    always #5 clk = ~clk;

    // Preset store model: data = addr + 5 after a fixed or random latency;
    // optionally raises a bogus valid during the read-strobe cycle.
    initial begin : mem_model
        logic [PRW+IW-1:0] addr;
        int lat;
        forever begin
            @(posedge clk); #1;
            if (mem_rd_en === 1'b1 && resetn === 1'b1) begin
                addr = mem_rd_addr;
                lat = rand_lat ? int'($urandom_range(1, 6)) : fix_lat;
                if (stray_en) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = 8'hEE;
                end
                repeat (lat) begin
                    @(posedge clk); #1;
                    mem_rd_valid = 1'b0;
                end
                mem_rd_valid = 1'b1;
                mem_rd_data  = PW'(addr) + 8'd5;
                @(posedge clk); #1;
                mem_rd_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_recall(input logic [PRW-1:0] id, input bit inject);
        n_rd = 0; n_lv = 0; busy_cyc = 0; first_lv = 0; first_rd = 0; bad_sel = 0;
        preset_id = id;
        preset_req = 1'b1;
        tick();
        preset_req = 1'b0;
        while (busy === 1'b1 && busy_cyc < 400) begin
            busy_cyc++;
            if (mem_rd_en === 1'b1) begin
                if (n_rd == 0) first_rd = busy_cyc;
                if (n_rd < 8) addr_log[n_rd] = mem_rd_addr;
                n_rd++;
            end
            if (load_valid !== '0) begin
                if (n_lv == 0) first_lv = busy_cyc;
                if (n_lv < 8) begin
                    lv_log[n_lv] = load_valid;
                    ld_log[n_lv] = load_data;
                end
                n_lv++;
            end
            if (sel_onehot !== '0 || restore !== 1'b0 || menu_active !== 1'b0) bad_sel++;
            if (inject) begin
                key_next    = (busy_cyc == 3);
                preset_req  = (busy_cyc == 7);
                preset_id   = 2'd3;
                key_prev    = (busy_cyc == 11);
                key_restore = (busy_cyc == 13);
            end
            tick();
        end
        key_next = 1'b0; key_prev = 1'b0; key_restore = 1'b0; preset_req = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        total++; if (sel_onehot !== '0) $display("FAIL reset_sel_onehot: got %h expected 00", sel_onehot); else passed++;
        total++; if (sel_idx !== '0) $display("FAIL reset_sel_idx: got %0d expected 0", sel_idx); else passed++;
        total++; if (menu_active !== 1'b0 || busy !== 1'b0) $display("FAIL reset_active_busy: got %b%b expected 00", menu_active, busy); else passed++;
        total++; if (mem_rd_en !== 1'b0 || load_valid !== '0 || restore !== 1'b0) $display("FAIL reset_strobes: got rd=%b lv=%h rs=%b expected 0", mem_rd_en, load_valid, restore); else passed++;
    endtask

    task automatic test_next_wrap();
        int exp_idx;
        for (int i = 0; i < 9; i++) begin
            key_next = 1'b1;
            tick();
            key_next = 1'b0;
            exp_idx = i % 8;
            total++; if (menu_active !== 1'b1) $display("FAIL next_active[%0d]: got %b expected 1", i, menu_active); else passed++;
            total++; if (sel_idx !== IW'(exp_idx)) $display("FAIL next_idx[%0d]: got %0d expected %0d", i, sel_idx, exp_idx); else passed++;
            total++; if (sel_onehot !== (NP'(1) << exp_idx)) $display("FAIL next_onehot[%0d]: got %h expected %h", i, sel_onehot, NP'(1) << exp_idx); else passed++;
        end
        key_prev = 1'b1;
        tick();
        key_prev = 1'b0;
        total++; if (sel_idx !== 3'd7 || sel_onehot !== 8'h80) $display("FAIL prev_wrap: got %0d/%h expected 7/80", sel_idx, sel_onehot); else passed++;
        key_next = 1'b1; key_prev = 1'b1;
        tick();
        key_next = 1'b0; key_prev = 1'b0;
        total++; if (sel_idx !== 3'd7) $display("FAIL both_keys: got %0d expected 7", sel_idx); else passed++;
    endtask

    task automatic test_restore();
        repeat (4) begin
            key_next = 1'b1;
            tick();
            key_next = 1'b0;
        end
        total++; if (sel_idx !== 3'd3) $display("FAIL restore_setup: got %0d expected 3", sel_idx); else passed++;
        key_restore = 1'b1;
        tick();
        key_restore = 1'b0;
        total++; if (restore !== 1'b1 || sel_onehot !== 8'h08) $display("FAIL restore_pulse: got %b/%h expected 1/08", restore, sel_onehot); else passed++;
        tick();
        total++; if (restore !== 1'b0 || sel_onehot !== 8'h08) $display("FAIL restore_single: got %b/%h expected 0/08", restore, sel_onehot); else passed++;
        key_restore = 1'b1; key_next = 1'b1;
        tick();
        key_restore = 1'b0; key_next = 1'b0;
        total++; if (restore !== 1'b1 || sel_idx !== 3'd3) $display("FAIL restore_priority: got %b/%0d expected 1/3", restore, sel_idx); else passed++;
        tick();
    endtask

    task automatic test_preset_l1();
        rand_lat = 1'b0; fix_lat = 1; stray_en = 1'b0;
        run_recall(2'd2, 1'b0);
        total++; if (first_rd !== 1) $display("FAIL l1_first_rd: got cycle %0d expected 1", first_rd); else passed++;
        total++; if (first_lv !== 3) $display("FAIL l1_first_lv: got cycle %0d expected 3", first_lv); else passed++;
        total++; if (busy_cyc !== 24) $display("FAIL l1_busy_len: got %0d expected 24", busy_cyc); else passed++;
        total++; if (n_rd !== 8 || n_lv !== 8) $display("FAIL l1_counts: got rd=%0d lv=%0d expected 8/8", n_rd, n_lv); else passed++;
        for (int k = 0; k < 8; k++) begin
            total++; if (addr_log[k] !== 5'(16 + k)) $display("FAIL l1_addr[%0d]: got %h expected %h", k, addr_log[k], 5'(16 + k)); else passed++;
            total++; if (lv_log[k] !== (NP'(1) << k)) $display("FAIL l1_lv[%0d]: got %h expected %h", k, lv_log[k], NP'(1) << k); else passed++;
            total++; if (ld_log[k] !== 8'(21 + k)) $display("FAIL l1_data[%0d]: got %0d expected %0d", k, ld_log[k], 21 + k); else passed++;
        end
        total++; if (bad_sel !== 0) $display("FAIL l1_sel_during_load: got %0d bad cycles expected 0", bad_sel); else passed++;
        total++; if (menu_active !== 1'b1 || sel_onehot !== 8'h08 || sel_idx !== 3'd3) $display("FAIL l1_return: got %b/%h/%0d expected 1/08/3", menu_active, sel_onehot, sel_idx); else passed++;
    endtask

    task automatic test_preset_random();
        int extra;
        rand_lat = 1'b1; stray_en = 1'b1;
        run_recall(2'd1, 1'b1);
        stray_en = 1'b0; rand_lat = 1'b0;
        total++; if (busy_cyc >= 400) $display("FAIL rnd_done: got busy for %0d cycles expected completion", busy_cyc); else passed++;
        total++; if (n_rd !== 8 || n_lv !== 8) $display("FAIL rnd_counts: got rd=%0d lv=%0d expected 8/8", n_rd, n_lv); else passed++;
        for (int k = 0; k < 8; k++) begin
            total++; if (addr_log[k] !== 5'(8 + k)) $display("FAIL rnd_addr[%0d]: got %h expected %h", k, addr_log[k], 5'(8 + k)); else passed++;
            total++; if (lv_log[k] !== (NP'(1) << k) || ld_log[k] !== 8'(13 + k)) $display("FAIL rnd_load[%0d]: got %h/%0d expected %h/%0d", k, lv_log[k], ld_log[k], NP'(1) << k, 13 + k); else passed++;
        end
        total++; if (bad_sel !== 0) $display("FAIL rnd_sel_during_load: got %0d bad cycles expected 0", bad_sel); else passed++;
        total++; if (sel_idx !== 3'd3 || menu_active !== 1'b1) $display("FAIL rnd_return: got %0d/%b expected 3/1", sel_idx, menu_active); else passed++;
        extra = 0;
        repeat (12) begin
            if (mem_rd_en !== 1'b0 || busy !== 1'b0 || load_valid !== '0) extra++;
            tick();
        end
        total++; if (extra !== 0) $display("FAIL rnd_no_queue: got %0d active cycles expected 0", extra); else passed++;
    endtask

    task automatic test_timeout();
        pulse_ms = 1'b1; tick(); pulse_ms = 1'b0; tick();
        pulse_ms = 1'b1; key_next = 1'b1; tick(); pulse_ms = 1'b0; key_next = 1'b0;
        total++; if (sel_idx !== 3'd4 || menu_active !== 1'b1) $display("FAIL to_key_restart: got %0d/%b expected 4/1", sel_idx, menu_active); else passed++;
        tick();
        pulse_ms = 1'b1; tick(); pulse_ms = 1'b0; tick();
        pulse_ms = 1'b1; tick(); pulse_ms = 1'b0;
        total++; if (menu_active !== 1'b1) $display("FAIL to_early: got active %b expected 1", menu_active); else passed++;
        tick();
        pulse_ms = 1'b1; tick(); pulse_ms = 1'b0;
        total++; if (menu_active !== 1'b0 || sel_onehot !== '0) $display("FAIL to_idle: got %b/%h expected 0/00", menu_active, sel_onehot); else passed++;
        tick();
        key_restore = 1'b1; tick(); key_restore = 1'b0;
        total++; if (restore !== 1'b0 || menu_active !== 1'b0) $display("FAIL idle_restore: got %b/%b expected 0/0", restore, menu_active); else passed++;
        key_prev = 1'b1; tick(); key_prev = 1'b0;
        total++; if (sel_idx !== 3'd4 || sel_onehot !== 8'h10 || menu_active !== 1'b1) $display("FAIL idle_resume: got %0d/%h/%b expected 4/10/1", sel_idx, sel_onehot, menu_active); else passed++;
    endtask

    task automatic test_reset_midload();
        int cyc, lv_cnt, stray;
        rand_lat = 1'b0; fix_lat = 6;
        preset_id = 2'd0; preset_req = 1'b1; tick(); preset_req = 1'b0;
        cyc = 0; lv_cnt = 0;
        while (!(mem_rd_en === 1'b1 && mem_rd_addr === 5'd4) && cyc < 300) begin
            if (load_valid !== '0) lv_cnt++;
            tick();
            cyc++;
        end
        total++; if (cyc >= 300 || lv_cnt !== 4) $display("FAIL ml_reach_idx4: got cyc=%0d lv=%0d expected <300/4", cyc, lv_cnt); else passed++;
        tick();
        total++; if (busy !== 1'b1 || load_data !== 8'd8) $display("FAIL ml_in_wait: got busy=%b data=%0d expected 1/8", busy, load_data); else passed++;
        resetn = 1'b0; tick();
        total++; if (busy !== 1'b0 || mem_rd_en !== 1'b0 || mem_rd_addr !== '0 || load_valid !== '0) $display("FAIL ml_reset_load: got %b/%b/%h/%h expected 0", busy, mem_rd_en, mem_rd_addr, load_valid); else passed++;
        total++; if (load_data !== '0 || sel_idx !== '0 || sel_onehot !== '0 || menu_active !== 1'b0 || restore !== 1'b0) $display("FAIL ml_reset_sel: got %h/%0d/%h/%b/%b expected 0", load_data, sel_idx, sel_onehot, menu_active, restore); else passed++;
        tick();
        resetn = 1'b1;
        stray = 0;
        repeat (30) begin
            tick();
            if (load_valid !== '0 || mem_rd_en !== 1'b0 || busy !== 1'b0) stray++;
        end
        total++; if (stray !== 0) $display("FAIL ml_after_release: got %0d active cycles expected 0", stray); else passed++;
    endtask

    initial begin
        test_reset();
        test_next_wrap();
        test_restore();
        test_preset_l1();
        test_preset_random();
        test_timeout();
        test_reset_midload();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/param_menu_ctrl.md
# param_menu_ctrl

Menu controller for a bank of NUM_PARAMS parameter cells in the on-screen tuning path. It owns which cell is selected (one-hot), routes the restore-to-default command to the selected cell, and returns to idle after an inactivity timeout. It also sequences preset recall: it reads NUM_PARAMS words from an external preset store and writes each word into its cell through that cell's load port.

## Interface
- NUM_PARAMS, 8: number of parameter cells, ≥2.
- IDX_WIDTH, 3: width of cell index; 2^IDX_WIDTH ≥ NUM_PARAMS.
- PARAM_WIDTH, 8: width of a parameter value.
- PRESET_WIDTH, 2: width of preset id.
- TIMEOUT_MS, 5000: inactivity timeout in ms, ≥1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; synchronous, active-low; clock clk.
- pulse_ms  in  1  one-cycle tick every 1 ms, clk domain.
- key_next  in  1  debounced press pulse (one cycle): select next cell.
- key_prev  in  1  debounced press pulse: select previous cell.
- key_restore  in  1  debounced press pulse: restore selected cell to default.
- preset_req  in  1  one-cycle request to recall preset preset_id.
- preset_id  in  PRESET_WIDTH  preset to recall; sampled with preset_req.
- mem_rd_en  out  1  one-cycle read strobe to preset store.
- mem_rd_addr  out  PRESET_WIDTH+IDX_WIDTH  {preset, index}.
- mem_rd_valid  in  1  read data valid; arbitrary latency ≥1 cycle after mem_rd_en.
- mem_rd_data  in  PARAM_WIDTH  read data.
- sel_onehot  out  NUM_PARAMS  per-cell selected.
- sel_idx  out  IDX_WIDTH  index of current/last selection.
- restore  out  1  one-cycle restore pulse, broadcast; only the selected cell acts.
- load_valid  out  NUM_PARAMS  one-hot, one-cycle load strobe per cell.
- load_data  out  PARAM_WIDTH  load value, shared by all cells.
- menu_active  out  1  high in ACTIVE.
- busy  out  1  high while a preset recall runs.

## Operation
- States: IDLE, ACTIVE, LD_RD, LD_WAIT, LD_WR.
- Reset values: all outputs 0. State IDLE, timeout counter 0, saved-return-state IDLE.
- IDLE: sel_onehot=0. key_next or key_prev → ACTIVE with sel_idx unchanged, so the last selection is resumed. key_restore is ignored.
- ACTIVE: sel_onehot = 1<<sel_idx.
  - key_next: sel_idx+1, wrapping NUM_PARAMS-1 → 0.
  - key_prev: sel_idx-1, wrapping 0 → NUM_PARAMS-1.
  - key_next and key_prev in the same cycle: no index change; the timeout counter still clears.
  - key_restore: restore=1 for one cycle. It has priority with the index keys; sel is not changed in that cycle.
- Timeout: the counter increments on pulse_ms in ACTIVE and clears on any key pulse or on entry to ACTIVE. When it reaches TIMEOUT_MS → IDLE.
- preset_req in IDLE or ACTIVE: latch preset_id, save the return state, index=0 → LD_RD. preset_req has priority over same-cycle keys, which are dropped.
- LD_RD: mem_rd_en=1 for one cycle, mem_rd_addr={preset,index} → LD_WAIT.
- LD_WAIT: hold until mem_rd_valid, then capture mem_rd_data into load_data → LD_WR.
- LD_WR: load_valid[index]=1 for one cycle.
  - If index=NUM_PARAMS-1 → return to the saved state; the timeout counter clears if returning to ACTIVE.
  - Otherwise index+1 → LD_RD.
- During a load (LD_*): busy=1, sel_onehot=0, restore=0. All key pulses and preset_req are ignored, not queued. mem_rd_valid outside LD_WAIT is ignored.
- load_data holds its last value outside LD_WR.
- Reset mid-load: immediate abort, all outputs to reset values, no further strobes.

## Timing
- All outputs are registered.
- Key pulse at cycle t → sel_idx/sel_onehot/restore/menu_active update at t+1.
- preset_req at t:
  - busy=1 and mem_rd_en=1 at t+1.
  - With read latency L (mem_rd_valid at t+1+L), load_valid at t+2+L.
  - The next mem_rd_en comes at t+3+L.
- Per-entry period is L+2 cycles. With L=1 a full recall is 3·NUM_PARAMS cycles.
- busy deasserts the cycle after the last load_valid. Restored sel_onehot/menu_active appear that same cycle.
- Timeout: with no keys, the IDLE transition occurs at the cycle after the TIMEOUT_MS-th pulse_ms following the last key.

## Test plan
- Reset, key_next ×9 with NUM_PARAMS=8 → menu_active=1 after the first press.
  - The first press selects sel_idx 0; the following presses step 1…7, then wrap to 0.
  - key_prev at idx 0 → 7.
- ACTIVE at idx 3, key_restore → restore=1 for exactly one cycle, sel_onehot=8'h08 throughout.
  - key_restore in IDLE → restore stays 0.
- preset_req, preset_id=2, store latency 1 (data=addr+5) → mem_rd_addr 5'h10…5'h17 in order.
  - load_valid walks 1<<0…1<<7 with load_data 21…28.
  - busy high for 24 cycles, then returns to the prior state.
- Recall with random latency 1–6; inject key_next, preset_req and stray mem_rd_valid during the load → all ignored.
  - sel_idx unchanged afterwards; exactly 8 load_valid strobes.
- TIMEOUT_MS=3: enter ACTIVE, give 3 pulse_ms → IDLE, sel_onehot=0.
  - A key at pulse 2 restarts the count.
- Assert resetn=0 during LD_WAIT of index 4 → all outputs 0 next cycle; no load_valid after release.
